// File: rtl/mips_alu_exec_unit_if.sv
// Operand/control bus and ALU outputs for the execute-stage slice.
// master drives the operands; slave is the execute unit.
interface mips_alu_exec_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic [2:0]         alu_op;
  logic [5:0]         funct;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         alu_ctrl;
  logic               jr_signal;
  logic               illegal;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;

  modport master (
    output alu_op, funct, shamt, a, b,
    input  alu_ctrl, jr_signal, illegal,
    input  result, zero, result_q, zero_q
  );

  modport slave (
    input  alu_op, funct, shamt, a, b,
    output alu_ctrl, jr_signal, illegal,
    output result, zero, result_q, zero_q
  );
endinterface

// File: rtl/mips_alu_exec_unit.sv
// Execute-stage ALU slice: alu_op/funct decode, 32-bit ALU,
// and a one-cycle registered copy of result and zero.
module mips_alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic Clock,
  input logic reset,
  mips_alu_exec_unit_if.slave bus
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_R   = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_LUI = 3'b110;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;

  logic [3:0]         ctrl;
  logic               jr;
  logic               ill;
  logic [5:0]         f;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SHAMT_W-1:0] sh;
  logic [WIDTH-1:0]   res;
  logic               res_zero;
  logic [WIDTH-1:0]   res_q;
  logic               zero_r;

  assign f    = bus.funct;
  assign op_a = bus.a;
  assign op_b = bus.b;
  assign sh   = bus.shamt;

  always_comb begin
    ctrl = ALU_ADD;
    jr   = 1'b0;
    ill  = 1'b0;
    unique case (bus.alu_op)
      OP_ADD: ctrl = ALU_ADD;
      OP_SUB: ctrl = ALU_SUB;
      OP_AND: ctrl = ALU_AND;
      OP_OR:  ctrl = ALU_OR;
      OP_SLT: ctrl = ALU_SLT;
      OP_LUI: ctrl = ALU_LUI;
      OP_R: begin
        unique case (1'b1)
          (f == F_ADD) || (f == F_ADDU): ctrl = ALU_ADD;
          (f == F_SUB) || (f == F_SUBU): ctrl = ALU_SUB;
          (f == F_AND):  ctrl = ALU_AND;
          (f == F_OR):   ctrl = ALU_OR;
          (f == F_XOR):  ctrl = ALU_XOR;
          (f == F_NOR):  ctrl = ALU_NOR;
          (f == F_SLT):  ctrl = ALU_SLT;
          (f == F_SLTU): ctrl = ALU_SLTU;
          (f == F_SLL):  ctrl = ALU_SLL;
          (f == F_SRL):  ctrl = ALU_SRL;
          (f == F_SRA):  ctrl = ALU_SRA;
          // jr still computes a+b; the flag steers the PC mux
          (f == F_JR): begin
            ctrl = ALU_ADD;
            jr   = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    res = '0;
    unique case (ctrl)
      ALU_AND:  res = op_a & op_b;
      ALU_OR:   res = op_a | op_b;
      ALU_ADD:  res = op_a + op_b;
      ALU_XOR:  res = op_a ^ op_b;
      ALU_SUB:  res = op_a - op_b;
      ALU_NOR:  res = ~(op_a | op_b);
      ALU_SLL:  res = op_b << sh;
      ALU_SRL:  res = op_b >> sh;
      ALU_SRA:  res = $unsigned($signed(op_b) >>> sh);
      ALU_SLT:
        res = {{(WIDTH-1){1'b0}},
               ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:
        res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      ALU_LUI:
        res = {op_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: res = '0;
    endcase
  end

  assign res_zero = (res == '0);

  always_ff @(posedge Clock) begin
    if (!reset) begin
      res_q  <= '0;
      zero_r <= 1'b1;
    end else begin
      res_q  <= res;
      zero_r <= res_zero;
    end
  end

  assign bus.alu_ctrl  = ctrl;
  assign bus.jr_signal = jr;
  assign bus.illegal   = ill;
  assign bus.result    = res;
  assign bus.zero      = res_zero;
  assign bus.result_q  = res_q;
  assign bus.zero_q    = zero_r;

endmodule

// File: tb/tb_mips_alu_exec_unit.sv
// Bench for mips_alu_exec_unit: inline combinational checks,
// registered outputs checked through an expected-value queue.
module tb_mips_alu_exec_unit;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  f;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        jr;
    logic        ill;
  } vec_t;

  logic Clock;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];

  mips_alu_exec_unit_if bus ();

  mips_alu_exec_unit dut (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic drive(input logic [2:0] op, input logic [5:0] f,
                       input logic [4:0] sh, input logic [31:0] a,
                       input logic [31:0] b);
    bus.alu_op = op;
    bus.funct  = f;
    bus.shamt  = sh;
    bus.a      = a;
    bus.b      = b;
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b0;
    drive(3'b000, 6'd0, 5'd0, 32'd5, 32'd7);
    repeat (2) tick();
    total++;
    if (bus.result_q !== 32'd0 || bus.zero_q !== 1'b1) begin
      bad++;
      $display("FAIL reset_q: got %h/%b want 0/1",
               bus.result_q, bus.zero_q);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.result !== 32'd12 || bus.zero !== 1'b0) begin
      bad++;
      $display("FAIL release_comb: got %h/%b want c/0",
               bus.result, bus.zero);
    end
    sb.push_back('{r: 32'd12, z: 1'b0});
    tick();
    e = sb.pop_front();
    total++;
    if (bus.result_q !== e.r || bus.zero_q !== e.z) begin
      bad++;
      $display("FAIL release_q: got %h/%b want %h/%b",
               bus.result_q, bus.zero_q, e.r, e.z);
    end
  endtask

  task automatic test_sub;
    vec_t v[2];
    exp_t e;
    v[0] = '{3'b001, 6'd0, 5'd0, 32'h1234, 32'h1234,
             4'b0110, 32'h0, 1'b0, 1'b0};
    v[1] = '{3'b001, 6'd0, 5'd0, 32'd3, 32'd4,
             4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      drive(v[i].op, v[i].f, v[i].sh, v[i].a, v[i].b);
      #1;
      total++;
      if (bus.alu_ctrl !== v[i].ctrl || bus.result !== v[i].res ||
          bus.zero !== (v[i].res == 0)) begin
        bad++;
        $display("FAIL sub[%0d]: got %b/%h/%b want %b/%h/%b", i,
                 bus.alu_ctrl, bus.result, bus.zero,
                 v[i].ctrl, v[i].res, v[i].res == 0);
      end
      sb.push_back('{r: v[i].res, z: v[i].res == 0});
      tick();
      e = sb.pop_front();
      total++;
      if (bus.result_q !== e.r || bus.zero_q !== e.z) begin
        bad++;
        $display("FAIL sub_q[%0d]: got %h/%b want %h/%b", i,
                 bus.result_q, bus.zero_q, e.r, e.z);
      end
    end
  endtask

  task automatic test_rtype;
    vec_t v[15];
    exp_t e;
    logic [5:0]  fs [15];
    logic [3:0]  cs [15];
    logic [31:0] rs [15];
    fs = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
           6'b100100, 6'b100101, 6'b100110, 6'b100111,
           6'b101010, 6'b101011, 6'b000000, 6'b000010,
           6'b000011, 6'b001000, 6'b111111};
    cs = '{4'b0010, 4'b0010, 4'b0110, 4'b0110,
           4'b0000, 4'b0001, 4'b0011, 4'b1100,
           4'b0111, 4'b1001, 4'b0100, 4'b0101,
           4'b1000, 4'b0010, 4'b0010};
    rs = '{32'h8000_0001, 32'h8000_0001, 32'h7FFF_FFFF,
           32'h7FFF_FFFF, 32'h0, 32'h8000_0001, 32'h8000_0001,
           32'h7FFF_FFFE, 32'h1, 32'h0, 32'h2, 32'h0, 32'h0,
           32'h8000_0001, 32'h8000_0001};
    for (int i = 0; i < 15; i++)
      v[i] = '{3'b010, fs[i], 5'd1, 32'h8000_0000, 32'h1,
               cs[i], rs[i], i == 13, i == 14};
    for (int i = 0; i < 15; i++) begin
      drive(v[i].op, v[i].f, v[i].sh, v[i].a, v[i].b);
      #1;
      total++;
      if (bus.alu_ctrl !== v[i].ctrl || bus.result !== v[i].res ||
          bus.jr_signal !== v[i].jr || bus.illegal !== v[i].ill ||
          bus.zero !== (v[i].res == 0)) begin
        bad++;
        $display("FAIL rtype[%b]: got %b/%h/jr%b/il%b want %b/%h/jr%b/il%b",
                 v[i].f, bus.alu_ctrl, bus.result, bus.jr_signal,
                 bus.illegal, v[i].ctrl, v[i].res, v[i].jr, v[i].ill);
      end
      sb.push_back('{r: v[i].res, z: v[i].res == 0});
      tick();
      e = sb.pop_front();
      total++;
      if (bus.result_q !== e.r || bus.zero_q !== e.z) begin
        bad++;
        $display("FAIL rtype_q[%b]: got %h/%b want %h/%b", v[i].f,
                 bus.result_q, bus.zero_q, e.r, e.z);
      end
    end
  endtask

  task automatic test_shift;
    vec_t v[3];
    v[0] = '{3'b010, 6'b000011, 5'd4, 32'h1234_5678, 32'h8000_0010,
             4'b1000, 32'hF800_0001, 1'b0, 1'b0};
    v[1] = '{3'b010, 6'b000010, 5'd4, 32'h1234_5678, 32'h8000_0010,
             4'b0101, 32'h0800_0001, 1'b0, 1'b0};
    v[2] = '{3'b010, 6'b000000, 5'd31, 32'hFFFF_FFFF, 32'h1,
             4'b0100, 32'h8000_0000, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(v[i].op, v[i].f, v[i].sh, v[i].a, v[i].b);
      #1;
      total++;
      if (bus.alu_ctrl !== v[i].ctrl || bus.result !== v[i].res) begin
        bad++;
        $display("FAIL shift[%0d]: got %b/%h want %b/%h", i,
                 bus.alu_ctrl, bus.result, v[i].ctrl, v[i].res);
      end
      tick();
    end
  endtask

  task automatic test_misc_ops;
    vec_t v[5];
    exp_t e;
    logic [2:0]  os [5];
    logic [3:0]  cs [5];
    logic [31:0] rs [5];
    os = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    cs = '{4'b0000, 4'b0001, 4'b0111, 4'b1010, 4'b0010};
    rs = '{32'h0, 32'h8000_ABCD, 32'h1, 32'hABCD_0000, 32'h8000_ABCD};
    for (int i = 0; i < 5; i++)
      v[i] = '{os[i], 6'b001000, 5'd3, 32'h8000_0000, 32'h0000_ABCD,
               cs[i], rs[i], 1'b0, i == 4};
    for (int i = 0; i < 5; i++) begin
      drive(v[i].op, v[i].f, v[i].sh, v[i].a, v[i].b);
      #1;
      total++;
      if (bus.alu_ctrl !== v[i].ctrl || bus.result !== v[i].res ||
          bus.jr_signal !== v[i].jr || bus.illegal !== v[i].ill) begin
        bad++;
        $display("FAIL op[%b]: got %b/%h/jr%b/il%b want %b/%h/jr%b/il%b",
                 v[i].op, bus.alu_ctrl, bus.result, bus.jr_signal,
                 bus.illegal, v[i].ctrl, v[i].res, v[i].jr, v[i].ill);
      end
      sb.push_back('{r: v[i].res, z: v[i].res == 0});
      tick();
      e = sb.pop_front();
      total++;
      if (bus.result_q !== e.r || bus.zero_q !== e.z) begin
        bad++;
        $display("FAIL op_q[%b]: got %h/%b want %h/%b", v[i].op,
                 bus.result_q, bus.zero_q, e.r, e.z);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    drive(3'b000, 6'd0, 5'd0, 32'hFFFF_FFFF, 32'h1);
    #1;
    total++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin
      bad++;
      $display("FAIL wrap: got %h/%b want 0/1", bus.result, bus.zero);
    end
    sb.push_back('{r: 32'h0, z: 1'b1});
    tick();
    e = sb.pop_front();
    total++;
    if (bus.result_q !== e.r || bus.zero_q !== e.z) begin
      bad++;
      $display("FAIL wrap_q: got %h/%b want %h/%b",
               bus.result_q, bus.zero_q, e.r, e.z);
    end
    drive(3'b000, 6'd0, 5'd0, 32'd5, 32'd7);
    tick();
    total++;
    if (bus.result_q !== 32'd12) begin
      bad++;
      $display("FAIL load_q: got %h want c", bus.result_q);
    end
    reset = 1'b0;
    drive(3'b100, 6'd0, 5'd0, 32'h1234_0000, 32'h0000_5678);
    tick();
    total++;
    if (bus.result_q !== 32'h0 || bus.zero_q !== 1'b1) begin
      bad++;
      $display("FAIL midreset_q: got %h/%b want 0/1",
               bus.result_q, bus.zero_q);
    end
    reset = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sub();
    test_rtype();
    test_shift();
    test_misc_ops();
    test_back_to_back();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_alu_exec_unit.md
Name: mips_alu_exec_unit

Overview:
- Execute-stage datapath slice for the single-cycle MIPS core.
- Decodes the 3-bit ALU_Op from main control and the R-type funct field into a 4-bit ALU control code and a jump-register flag.
- Performs the 32-bit ALU operation combinationally and also presents a registered copy of the result and zero flag, clocked by the core clock.

Parameters:
- WIDTH, 32, datapath width. Only 32 is required.
- SHAMT_W, 5, shift-amount width.

Ports:
- Clock  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- alu_op  input  3  ALU operation class from main control.
- funct  input  6  instruction[5:0].
- shamt  input  5  instruction[10:6].
- a  input  32  operand A (rs read data).
- b  input  32  operand B (rt data or sign-extended immediate, after the ALUSrc mux).
- alu_ctrl  output  4  decoded ALU control code.
- jr_signal  output  1  high for R-type jr (funct 001000).
- illegal  output  1  high for an unknown R-type funct or an unused alu_op.
- result  output  32  combinational ALU result.
- zero  output  1  combinational; 1 when result == 0.
- result_q  output  32  registered result.
- zero_q  output  1  registered zero flag.

Behaviour:
- Interface (already decided): one clock, Clock; reset is synchronous and active-low; reset is sampled only on the rising edge of Clock.

ALU control codes:
- 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT, 1000 SRA, 1001 SLTU, 1010 LUI, 1100 NOR.

alu_op decode:
- 000 ADD (lw/sw/addi)
- 001 SUB (beq/bne)
- 010 R-type, use funct
- 011 AND (andi)
- 100 OR (ori)
- 101 SLT (slti)
- 110 LUI
- 111 unused: ADD with illegal=1

R-type funct decode (alu_op = 010):
- 100000/100001 ADD; 100010/100011 SUB
- 100100 AND; 100101 OR; 100110 XOR; 100111 NOR
- 101010 SLT; 101011 SLTU
- 000000 SLL; 000010 SRL; 000011 SRA
- 001000 jr: ADD and jr_signal=1
- Any other funct: ADD with illegal=1.
- jr_signal is 0 whenever alu_op != 010.

ALU operations:
- ADD/SUB: modulo 2^32; no overflow flag.
- SLT: signed a<b gives 1, else 0. SLTU: unsigned compare.
- SLL/SRL/SRA shift operand b by shamt; operand a is ignored.
- SRA replicates b[31].
- LUI: result = {b[15:0], 16'h0000}.
- NOR: ~(a|b).

Combinational paths:
- alu_ctrl, jr_signal, illegal, result and zero are purely combinational from the inputs, with no clock dependency.

Registered stage:
- On a rising edge with reset=0: result_q <= 0, zero_q <= 1.
- Otherwise result_q <= result and zero_q <= zero. One-cycle latency; the registers load every cycle.
- Reset asserted mid-stream overrides the load on that same edge.
- Before the first edge the register values are undefined; the bench must apply reset first.

Test Plan:
- Hold reset=0 for 2 edges -> result_q=0, zero_q=1. Release reset with alu_op=000, a=5, b=7 -> result=12 immediately; result_q=12 after the next edge.
- alu_op=001, a=b=0x1234 -> alu_ctrl=0110, result=0, zero=1. With a=3, b=4 -> result=0xFFFFFFFF, zero=0.
- alu_op=010 with each of the 14 listed functs, a=0x80000000, b=0x00000001 -> correct codes. SLT=1, SLTU=0, jr_signal=1 only for 001000.
- alu_op=010, funct=000011, b=0x80000010, shamt=4 -> 0xF8000001. funct=000010 -> 0x08000001. funct=000000, shamt=31, b=1 -> 0x80000000.
- alu_op=110, b=0x0000ABCD -> result=0xABCD0000. alu_op=111 -> illegal=1, ADD result.
- Wrap case a=0xFFFFFFFF, b=1, ADD -> result=0, zero=1. Assert reset on the next edge -> result_q=0, zero_q=1 regardless of inputs.
